move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Sequences one 2048 move across video frames: slide animation, then merge, then tile spawn.
- Accepts debounced direction pulses and holds one pending move.
- Paces the slide phase with the per-frame strobe and hands off to board-update logic through start/done handshakes.
- Sits between button conditioning and the board/tile datapath; the renderer reads its animation frame count.

Parameters:
- ANIM_FRAMES, 8, number of frame_stb pulses in the slide phase (legal range 1..2^FRAME_W).
- FRAME_W, 4, width of anim_frame; must satisfy 2^FRAME_W >= ANIM_FRAMES.

Ports:
- CLK100MHZ  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_stb  in  1  one-cycle pulse per video frame.
- btn_dir  in  4  one-cycle direction pulses: bit0 up, bit1 down, bit2 left, bit3 right.
- game_over  in  1  level; while high, no new move launches.
- merge_done  in  1  one-cycle pulse; board merge finished.
- merge_moved  in  1  sampled with merge_done; 1 = board changed.
- spawn_done  in  1  one-cycle pulse; new tile placed.
- slide_dir  out  2  encoded direction of the current move (0 up, 1 down, 2 left, 3 right).
- slide_start  out  1  one-cycle pulse; slide begins.
- anim_frame  out  FRAME_W  frames elapsed in the slide phase.
- merge_start  out  1  one-cycle pulse.
- spawn_start  out  1  one-cycle pulse.
- busy  out  1  high in every state except IDLE.
- drop  out  1  one-cycle pulse; a request was discarded.

Behaviour:
- States: IDLE, SLIDE, MERGE, SPAWN. All outputs are registered.
- Reset: state IDLE; pending cleared; slide_dir=0; anim_frame=0; all pulse outputs=0; busy=0. Reset mid-move aborts the move immediately; no done handshake is awaited afterwards.
- Direction select: when several btn_dir bits are set, priority is up > down > left > right.
- IDLE:
  - A nonzero btn_dir with game_over=0 latches slide_dir and moves to SLIDE.
  - slide_start=1 in the first SLIDE cycle, 1 cycle after the button pulse. anim_frame=0.
  - A nonzero btn_dir with game_over=1 is ignored and does not assert drop.
- SLIDE:
  - Each frame_stb increments anim_frame.
  - On the frame_stb where anim_frame==ANIM_FRAMES-1: go to MERGE, set anim_frame=0, and pulse merge_start in the first MERGE cycle.
- MERGE:
  - Wait for merge_done.
  - merge_moved=1: go to SPAWN and pulse spawn_start in the first SPAWN cycle.
  - merge_moved=0: take the exit path (no spawn).
- SPAWN: wait for spawn_done, then take the exit path.
- Exit path (same cycle as the completing done pulse):
  - Pending valid and game_over=0: launch pending into SLIDE (slide_start next cycle) and clear pending.
  - Otherwise go to IDLE and clear pending.
- Pending buffer (one entry):
  - A btn_dir in SLIDE, MERGE or SPAWN is stored if pending is empty.
  - If pending is already full, drop pulses and the first-stored move is kept.
- Simultaneous events in the exit cycle:
  - Pending valid: pending launches and the new btn is dropped (drop=1).
  - Pending empty: the btn launches directly.
- Stray pulses:
  - merge_done or spawn_done outside its own state is ignored.
  - frame_stb outside SLIDE is ignored.
- busy=1 exactly when the state is not IDLE.

Decomposition:
- Shared package move_pkg:
  - State encoding.
  - Direction constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - Priority-encode function from 4-bit one-hot to 2-bit direction.
- Sub-module move_pending_buf: one-entry buffer with valid, store, consume and drop logic.
- FSM and frame counter stay in the top module.

Test Plan:
- Basic move: reset, then btn_dir=4'b0100 -> slide_start 1 cycle later with slide_dir=2. After 8 frame_stb, merge_start. Drive merge_done with merge_moved=1 -> spawn_start. Drive spawn_done -> next cycle busy=0.
- No-move skip: move with merge_done and merge_moved=0 -> spawn_start never asserts; IDLE next cycle.
- Pending and drop: during SLIDE send btn_dir=4'b0001, then btn_dir=4'b1000 -> drop pulses once. After the first move completes, slide_start fires with slide_dir=0.
- Priority and game_over: btn_dir=4'b1010 -> slide_dir=1. With game_over=1, btn_dir=4'b0001 in IDLE -> no slide_start and no drop.
- Reset mid-op: assert reset in MERGE with pending valid -> next cycle all outputs zero. A later merge_done produces no merge_start or spawn_start.
- Edge timing: frame_stb in the same cycle as a launch from IDLE is not counted (anim_frame=0 in the first SLIDE cycle). With ANIM_FRAMES=1, merge_start follows the first frame_stb in SLIDE.

Source files
------------

// File: rtl/move_pkg.sv
// Shared definitions for the 2048 move sequencer: state encoding, directions,
// and the button priority encoder.
package move_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SLIDE = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;
    localparam logic [1:0] ST_SPAWN = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Priority up > down > left > right; caller guarantees btn is nonzero.
    function automatic logic [1:0] dir_encode(input logic [3:0] btn);
        if (btn[0]) begin
            return DIR_UP;
        end else if (btn[1]) begin
            return DIR_DOWN;
        end else if (btn[2]) begin
            return DIR_LEFT;
        end else begin
            return DIR_RIGHT;
        end
    endfunction

endpackage

// File: rtl/move_pending_buf.sv
// One-entry buffer for a direction requested while a move is in flight.
// The first stored request is kept; later requests while full are dropped.
module move_pending_buf
    import move_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       clear_i,
    input  logic [1:0] dir_i,
    output logic       valid_o,
    output logic [1:0] dir_o,
    output logic       drop_o
);

    logic       valid_q, valid_d;
    logic [1:0] dir_q, dir_d;

    always_comb begin
        valid_d = valid_q;
        dir_d   = dir_q;
        drop_o  = req_i && valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (req_i && !valid_q) begin
            valid_d = 1'b1;
            dir_d   = dir_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            valid_q <= valid_d;
            dir_q   <= dir_d;
        end
    end

    assign valid_o = valid_q;
    assign dir_o   = dir_q;

endmodule

// File: rtl/move_sequencer.sv
// Sequences one 2048 move: frame-paced slide, then merge, then optional spawn,
// with a one-entry pending buffer for directions pressed mid-move.
module move_sequencer
    import move_pkg::*;
#(
    parameter int ANIM_FRAMES = 8,
    parameter int FRAME_W     = 4
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic               frame_stb,
    input  logic [3:0]         btn_dir,
    input  logic               game_over,
    input  logic               merge_done,
    input  logic               merge_moved,
    input  logic               spawn_done,
    output logic [1:0]         slide_dir,
    output logic               slide_start,
    output logic [FRAME_W-1:0] anim_frame,
    output logic               merge_start,
    output logic               spawn_start,
    output logic               busy,
    output logic               drop
);

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(ANIM_FRAMES - 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         slide_dir_q, slide_dir_d;
    logic [FRAME_W-1:0] anim_q, anim_d;
    logic               slide_start_q, slide_start_d;
    logic               merge_start_q, merge_start_d;
    logic               spawn_start_q, spawn_start_d;
    logic               busy_q, busy_d;
    logic               drop_q;

    logic       btn_any;
    logic [1:0] btn_enc;
    logic       exit_now;
    logic       pend_req, pend_clear, pend_valid, pend_drop;
    logic [1:0] pend_dir;

    assign btn_any = |btn_dir;
    assign btn_enc = dir_encode(btn_dir);

    move_pending_buf u_pend (
        .clk     (CLK100MHZ),
        .reset   (reset),
        .req_i   (pend_req),
        .clear_i (pend_clear),
        .dir_i   (btn_enc),
        .valid_o (pend_valid),
        .dir_o   (pend_dir),
        .drop_o  (pend_drop)
    );

    always_comb begin
        state_d       = state_q;
        slide_dir_d   = slide_dir_q;
        anim_d        = anim_q;
        slide_start_d = 1'b0;
        merge_start_d = 1'b0;
        spawn_start_d = 1'b0;
        exit_now      = 1'b0;
        pend_clear    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_any && !game_over) begin
                    state_d       = ST_SLIDE;
                    slide_dir_d   = btn_enc;
                    slide_start_d = 1'b1;
                    anim_d        = '0;
                end
            end
            ST_SLIDE: begin
                if (frame_stb) begin
                    if (anim_q == LAST_FRAME) begin
                        state_d       = ST_MERGE;
                        anim_d        = '0;
                        merge_start_d = 1'b1;
                    end else begin
                        anim_d = anim_q + 1'b1;
                    end
                end
            end
            ST_MERGE: begin
                if (merge_done) begin
                    if (merge_moved) begin
                        state_d       = ST_SPAWN;
                        spawn_start_d = 1'b1;
                    end else begin
                        exit_now = 1'b1;
                    end
                end
            end
            ST_SPAWN: begin
                if (spawn_done) begin
                    exit_now = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Exit path: a pending move wins over a button arriving in the same
        // cycle; with nothing pending that button launches directly.
        if (exit_now) begin
            pend_clear = 1'b1;
            anim_d     = '0;
            if (pend_valid) begin
                if (!game_over) begin
                    state_d       = ST_SLIDE;
                    slide_dir_d   = pend_dir;
                    slide_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end else if (btn_any && !game_over) begin
                state_d       = ST_SLIDE;
                slide_dir_d   = btn_enc;
                slide_start_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        pend_req = btn_any && (state_q != ST_IDLE) && !(exit_now && !pend_valid);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slide_dir_q   <= DIR_UP;
            anim_q        <= '0;
            slide_start_q <= 1'b0;
            merge_start_q <= 1'b0;
            spawn_start_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            slide_dir_q   <= slide_dir_d;
            anim_q        <= anim_d;
            slide_start_q <= slide_start_d;
            merge_start_q <= merge_start_d;
            spawn_start_q <= spawn_start_d;
            busy_q        <= busy_d;
            drop_q        <= pend_drop;
        end
    end

    assign slide_dir   = slide_dir_q;
    assign slide_start = slide_start_q;
    assign anim_frame  = anim_q;
    assign merge_start = merge_start_q;
    assign spawn_start = spawn_start_q;
    assign busy        = busy_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: two instances (ANIM_FRAMES 8 and 1)
// share random stimulus and are checked against a transaction-level model.
module tb_move_sequencer;

    localparam int K_SLIDE = 0;
    localparam int K_MERGE = 1;
    localparam int K_SPAWN = 2;
    localparam int K_DROP  = 3;

    typedef struct {
        int stamp;
        int inst;
        int kind;
        int dir;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_stb = 1'b0;
    logic [3:0] btn_dir = 4'd0;
    logic       game_over = 1'b0;
    logic       merge_done = 1'b0;
    logic       merge_moved = 1'b0;
    logic       spawn_done = 1'b0;

    logic [1:0] sdir0, sdir1;
    logic       ss0, ss1, ms0, ms1, sp0, sp1, busy0, busy1, drop0, drop1;
    logic [3:0] anim0;
    logic [0:0] anim1;

    always #5 clk = ~clk;

    move_sequencer #(.ANIM_FRAMES(8), .FRAME_W(4)) u_dut0 (
        .CLK100MHZ(clk), .reset(rst), .frame_stb(frame_stb), .btn_dir(btn_dir),
        .game_over(game_over), .merge_done(merge_done), .merge_moved(merge_moved),
        .spawn_done(spawn_done), .slide_dir(sdir0), .slide_start(ss0),
        .anim_frame(anim0), .merge_start(ms0), .spawn_start(sp0), .busy(busy0),
        .drop(drop0)
    );

    move_sequencer #(.ANIM_FRAMES(1), .FRAME_W(1)) u_dut1 (
        .CLK100MHZ(clk), .reset(rst), .frame_stb(frame_stb), .btn_dir(btn_dir),
        .game_over(game_over), .merge_done(merge_done), .merge_moved(merge_moved),
        .spawn_done(spawn_done), .slide_dir(sdir1), .slide_start(ss1),
        .anim_frame(anim1), .merge_start(ms1), .spawn_start(sp1), .busy(busy1),
        .drop(drop1)
    );

    // ---------------- reference model ----------------
    int   anim_len [2] = '{8, 1};
    int   phase    [2];   // 0 idle, 1 slide, 2 merge, 3 spawn
    int   frames   [2];
    int   cur_dir  [2];
    bit   pend_v   [2];
    int   pend_d   [2];
    ev_t  expq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    function automatic int first_dir(input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) return i;
        end
        return 0;
    endfunction

    task automatic push_ev(input int n, input int kind, input int dir);
        ev_t e;
        e.stamp = cyc;
        e.inst  = n;
        e.kind  = kind;
        e.dir   = dir;
        expq.push_back(e);
    endtask

    task automatic model_step(input int n);
        bit btn = (btn_dir != 4'd0);
        int bd  = first_dir(btn_dir);
        bit was_busy = (phase[n] != 0);
        bit done = 0;
        bit e_s = 0, e_m = 0, e_sp = 0, e_d = 0;
        int launch_dir = -1;
        if (rst) begin
            phase[n] = 0; frames[n] = 0; cur_dir[n] = 0; pend_v[n] = 0;
            return;
        end
        case (phase[n])
            0: if (btn && !game_over) launch_dir = bd;
            1: if (frame_stb) begin
                frames[n]++;
                if (frames[n] == anim_len[n]) begin
                    phase[n] = 2; frames[n] = 0; e_m = 1;
                end
            end
            2: if (merge_done) begin
                if (merge_moved) begin phase[n] = 3; e_sp = 1; end
                else done = 1;
            end
            default: if (spawn_done) done = 1;
        endcase
        if (done) begin
            if (pend_v[n]) begin
                if (btn) e_d = 1;
                if (!game_over) launch_dir = pend_d[n];
                else phase[n] = 0;
                pend_v[n] = 0;
            end else if (btn && !game_over) begin
                launch_dir = bd;
            end else begin
                phase[n] = 0;
            end
        end else if (was_busy && btn) begin
            if (pend_v[n]) e_d = 1;
            else begin pend_v[n] = 1; pend_d[n] = bd; end
        end
        if (launch_dir >= 0) begin
            phase[n] = 1; frames[n] = 0; cur_dir[n] = launch_dir; e_s = 1;
        end
        if (e_s)  push_ev(n, K_SLIDE, launch_dir);
        if (e_m)  push_ev(n, K_MERGE, 0);
        if (e_sp) push_ev(n, K_SPAWN, 0);
        if (e_d)  push_ev(n, K_DROP, 0);
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int n, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", name, n, cyc, act, exp);
    endtask

    task automatic mon_inst(input int n, input bit s, input bit m, input bit sp,
                            input bit d, input int dir, input bit bz, input int an);
        bit evs [4];
        evs[0] = s; evs[1] = m; evs[2] = sp; evs[3] = d;
        for (int k = 0; k < 4; k++) begin
            if (evs[k]) begin
                if (expq.size() > 0 && expq[0].stamp == cyc && expq[0].inst == n
                    && expq[0].kind == k) begin
                    if (k == K_SLIDE) chk("slide_dir_at_start", n, dir, expq[0].dir);
                    else chk("event_expected", n, 1, 1);
                    void'(expq.pop_front());
                end else begin
                    chk($sformatf("unexpected_event_kind%0d", k), n, 1, 0);
                end
            end
        end
        while (expq.size() > 0 && expq[0].stamp <= cyc && expq[0].inst == n) begin
            chk($sformatf("missing_event_kind%0d", expq[0].kind), n, 0, 1);
            void'(expq.pop_front());
        end
        chk("busy", n, int'(bz), int'(phase[n] != 0));
        chk("anim_frame", n, an, frames[n]);
        chk("slide_dir", n, dir, cur_dir[n]);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            mon_inst(0, ss0, ms0, sp0, drop0, int'(sdir0), busy0, int'(anim0));
            mon_inst(1, ss1, ms1, sp1, drop1, int'(sdir1), busy1, int'(anim1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic fs, input logic [3:0] b, input logic md,
                        input logic mm, input logic sd, input logic r);
        frame_stb = fs; btn_dir = b; merge_done = md; merge_moved = mm;
        spawn_done = sd; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic frames8();
        for (int i = 0; i < 8; i++) begin
            step(1, 4'd0, 0, 0, 0, 0);
            idle(1);
        end
    endtask

    initial begin
        logic [3:0] rb;
        step(0, 4'd0, 0, 0, 0, 1);
        step(0, 4'd0, 0, 0, 0, 1);
        idle(2);
        // basic move
        step(0, 4'b0100, 0, 0, 0, 0); idle(2); frames8();
        step(0, 4'd0, 1, 1, 0, 0); idle(1); step(0, 4'd0, 0, 0, 1, 0); idle(2);
        // merge without movement skips spawn
        step(0, 4'b0010, 0, 0, 0, 0); frames8(); step(0, 4'd0, 1, 0, 0, 0); idle(2);
        // pending stored, second press dropped
        step(0, 4'b0100, 0, 0, 0, 0); idle(1); step(0, 4'b0001, 0, 0, 0, 0); idle(1);
        step(0, 4'b1000, 0, 0, 0, 0); frames8(); step(0, 4'd0, 1, 1, 0, 0);
        step(0, 4'd0, 0, 0, 1, 0); idle(1); frames8(); step(0, 4'd0, 1, 0, 0, 0); idle(2);
        // priority, then game_over blocks launch
        step(0, 4'b1010, 0, 0, 0, 0); frames8(); step(0, 4'd0, 1, 0, 0, 0); idle(1);
        game_over = 1'b1; step(0, 4'b0001, 0, 0, 0, 0); idle(3); game_over = 1'b0;
        // reset mid-merge with pending, stray done afterwards
        step(0, 4'b0100, 0, 0, 0, 0); frames8(); step(0, 4'b0001, 0, 0, 0, 0);
        step(0, 4'd0, 0, 0, 0, 1); idle(1); step(0, 4'd0, 1, 1, 0, 0);
        step(0, 4'd0, 0, 0, 1, 0); idle(2);
        // frame_stb coinciding with launch from idle
        step(1, 4'b0010, 0, 0, 0, 0); idle(1); frames8(); step(0, 4'd0, 1, 0, 0, 0); idle(2);
        // exit cycle with pending plus new press, then exit with empty pending plus press
        step(0, 4'b0001, 0, 0, 0, 0); frames8(); step(0, 4'b1000, 0, 0, 0, 0);
        step(0, 4'b0100, 1, 0, 0, 0); frames8(); step(0, 4'b0010, 1, 0, 0, 0);
        frames8(); step(0, 4'd0, 1, 0, 0, 0); idle(2);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) game_over = ~game_over;
            rb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(($urandom_range(0, 3) == 0), rb, ($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 399) == 0));
        end
        game_over = 1'b0;
        idle(3);
        chk("leftover_expected_events", 0, expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
